// File: rtl/cp_result_packer_if.sv
// Bus between the co-processor result stream, the packer and the byte consumer.
//
// Handshake:
// - Bit side: a bit is taken on every rising edge where bit_valid is high.
//   There is no backpressure: the packer always accepts bits, and drops
//   whole bytes (setting overflow) if its FIFO is full.
//   flush asks for any partial byte to be pushed, zero-padded.
// - Byte side: rd_valid/rd_ready.
//   rd_valid is high while the FIFO holds a byte, and rd_data is that byte.
//   A byte is consumed on the edge where rd_valid and rd_ready are both high.
//   rd_ready while rd_valid is low has no effect, and rd_data is 8'h00 then.
interface cp_result_packer_if;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;

  // Producer/consumer side.
  modport master (
    output bit_in, bit_valid, flush, rd_ready,
    input  rd_data, rd_valid
  );

  // Packer side.
  modport slave (
    input  bit_in, bit_valid, flush, rd_ready,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/cp_result_packer.sv
// Serial-to-byte packer for co-processor result bits.
// Bits are assembled LSB-first into a byte and pushed into a small circular
// FIFO for a byte-wide consumer. A flush pushes a partial byte zero-padded.
// A byte pushed into a full FIFO with no pop on the same edge is dropped,
// and the sticky overflow flag is set.
module cp_result_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cp_result_packer_if.slave        bus,
  output logic [2:0]               bit_count_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Assembly register and its fill count.
  logic [7:0]    asm_q, asm_d;
  logic [2:0]    cnt_q, cnt_d;
  // FIFO storage and bookkeeping.
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // Per-edge events.
  logic [7:0]    asm_with_bit;
  logic          byte_done;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;

  // Fold the incoming bit into the byte being assembled and decide whether
  // this edge pushes. Completing a byte and flushing together pushes exactly
  // once. A flush with nothing held pushes nothing.
  always_comb begin
    asm_with_bit = asm_q;
    if (bus.bit_valid) begin
      asm_with_bit[cnt_q] = bus.bit_in;
    end
    byte_done = bus.bit_valid && (cnt_q == 3'd7);
    push      = byte_done || (bus.flush && (bus.bit_valid || (cnt_q != 3'd0)));
  end

  // Next state of the assembly register. After any push it clears, even if
  // the byte was dropped, so the upper bits of a partial byte are always zero.
  always_comb begin
    asm_d = asm_with_bit;
    cnt_d = cnt_q;
    if (push) begin
      asm_d = 8'h00;
      cnt_d = 3'd0;
    end else if (bus.bit_valid) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // FIFO control. A pop frees a slot on the same edge, so a push into a full
  // FIFO still succeeds when the consumer takes the head at the same time.
  always_comb begin
    full     = (level_q == LVL_FULL);
    pop      = (level_q != '0) && bus.rd_ready;
    push_ok  = push && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push_ok && pop) begin
      level_d = level_q - LVL_ONE;
    end
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Assembly and FIFO control registers. Reset discards all held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q    <= 8'h00;
      cnt_q    <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage. Only the slot at the write pointer changes, and only on an
  // accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= asm_with_bit;
    end
  end

  // The head byte is masked to zero while the FIFO is empty.
  assign bus.rd_valid = (level_q != '0);
  assign bus.rd_data  = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bit_count_o  = cnt_q;
  assign level_o      = level_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_cp_result_packer.sv
// Self-checking bench for cp_result_packer (DEPTH = 4).
module tb_cp_result_packer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [2:0]    bit_count;
  logic [LW-1:0] level;
  logic          overflow;

  cp_result_packer_if bus ();

  cp_result_packer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .bit_count_o (bit_count),
    .level_o     (level),
    .overflow_o  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] m_asm;
  int         m_cnt;
  logic       m_ovf;
  int         checks;
  int         errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_asm = 8'h00;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_level"},     32'(level),        32'(exp_q.size()));
    check_eq({tag, "_bit_count"}, 32'(bit_count),    32'(m_cnt));
    check_eq({tag, "_overflow"},  32'(overflow),     32'(m_ovf));
    check_eq({tag, "_rd_valid"},  32'(bus.rd_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_rd_data_empty"}, 32'(bus.rd_data), 32'h0);
    end
  endtask

  // One clock cycle: drive inputs, pop/compare on consumer acceptance,
  // advance the model, then check status 1 time unit after the edge.
  task automatic cycle(input logic bv, input logic b, input logic fl, input logic rr);
    logic [7:0] head;
    bit         push;
    bus.bit_valid = bv;
    bus.bit_in    = b;
    bus.flush     = fl;
    bus.rd_ready  = rr;
    if (rr && exp_q.size() != 0) begin
      head = exp_q.pop_front();
      check_eq("pop_data", 32'(bus.rd_data), 32'(head));
    end
    if (bv) begin
      m_asm[m_cnt] = b;
      m_cnt++;
    end
    push = (m_cnt == 8) || (fl && m_cnt > 0);
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(m_asm);
      else m_ovf = 1'b1;
      m_asm = 8'h00;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    check_status("cyc");
  endtask

  // Send a whole byte LSB-first; rr applies on the last bit only.
  task automatic send_byte(input logic [7:0] v, input logic rr_last);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, v[k], 1'b0, (k == 7) ? rr_last : 1'b0);
    end
  endtask

  // Drain the FIFO with a bounded cycle budget.
  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2 * DEPTH + 4) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    check_eq("drain_budget", 32'(exp_q.size()), 32'h0);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic pulse_reset(input string tag);
    bus.bit_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.bit_in    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_status(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_status({tag, "_rel"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pat;
    checks = 0;
    errors = 0;
    model_clear();
    rst_n         = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.rd_ready  = 1'b0;
    #3;
    check_status("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_status("reset_rel");

    // First byte after reset: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
    pat = 8'h4D;
    send_byte(pat, 1'b0);
    check_eq("b4d_data",  32'(bus.rd_data), 32'h4D);
    check_eq("b4d_level", 32'(level),       32'h1);
    check_eq("b4d_cnt",   32'(bit_count),   32'h0);
    drain();

    // Partial byte flush: 1,1,1 then flush -> 8'h07; lone flush is a no-op.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("part_cnt", 32'(bit_count), 32'h3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("flush_data", 32'(bus.rd_data), 32'h07);
    check_eq("flush_cnt",  32'(bit_count),   32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("flush2_level", 32'(level), 32'h1);
    drain();

    // Flush with the completing bit: exactly one 8'hFF.
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("ff_data",  32'(bus.rd_data), 32'hFF);
    check_eq("ff_level", 32'(level),       32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ff_level_hold", 32'(level), 32'h1);
    drain();

    // Flush together with a non-completing bit: 2 bits + flush -> 8'h05.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("pflush_data", 32'(bus.rd_data), 32'h05);
    drain();

    // Overflow: five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    check_eq("ovf_level", 32'(level),    32'h4);
    check_eq("ovf_flag",  32'(overflow), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_sticky_flush", 32'(overflow), 32'h1);
    drain();
    check_eq("ovf_empty_valid", 32'(bus.rd_valid), 32'h0);
    check_eq("ovf_sticky_empty", 32'(overflow), 32'h1);

    // Full FIFO with simultaneous push and pop.
    pulse_reset("rst_a");
    for (int i = 1; i <= 4; i++) send_byte(8'(8'h10 + i), 1'b0);
    send_byte(8'hA5, 1'b1);
    check_eq("full_pp_level", 32'(level),    32'h4);
    check_eq("full_pp_ovf",   32'(overflow), 32'h0);
    drain();

    // Mid-level push and pop: level unchanged.
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h5A, 1'b1);
    check_eq("mid_pp_level", 32'(level), 32'h2);

    // Async reset with 4 bits held and 2 bytes queued.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_level", 32'(level),     32'h2);
    check_eq("pre_rst_cnt",   32'(bit_count), 32'h4);
    pulse_reset("rst_b");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp_result_packer.md
CP_RESULT_PACKER -- requirements
Module: cp_result_packer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of byte entries in the output FIFO (power of two, 2..16).
REQ-002 clk  input  1  clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 bit_in  input  1  result bit from the co-processor Q output.
REQ-005 bit_valid  input  1  bit_in is accepted on this clock edge when high.
REQ-006 flush  input  1  when high, push any partial byte into the FIFO, zero-padded.
REQ-007 rd_ready  input  1  consumer accepts rd_data this edge when high and rd_valid is high.
REQ-008 rd_data  output  8  byte at FIFO head; 8'h00 when FIFO empty.
REQ-009 rd_valid  output  1  FIFO non-empty.
REQ-010 bit_count  output  3  number of bits held in the assembly register (0..7).
REQ-011 level  output  clog2(DEPTH)+1  number of bytes in the FIFO (0..DEPTH).
REQ-012 overflow  output  1  sticky flag, a byte was dropped because the FIFO was full.

Function
REQ-013 Assembly SHALL be LSB-first: the k-th accepted bit since the last push (k=0..7) lands in byte bit k.
REQ-014 Each edge with bit_valid=1 SHALL store bit_in at position bit_count and increment bit_count modulo 8.
REQ-015 On the edge accepting the 8th bit, the completed byte SHALL be pushed to the FIFO and bit_count SHALL wrap to 0; rd_valid/rd_data reflect it from that edge (1-cycle latency from bit_valid to rd_valid when FIFO was empty).
REQ-016 flush with bit_count>0 and bit_valid=0 SHALL push the held bits with unused upper bits zero, and clear bit_count to 0.
REQ-017 flush with bit_count=0 and bit_valid=0 SHALL be a no-op (no push of an empty byte).
REQ-018 flush and bit_valid in the same cycle SHALL first include bit_in, then push the (possibly still partial) byte; exactly one push occurs, including when bit_in completes the byte.
REQ-019 A pop SHALL occur on any edge where rd_valid=1 and rd_ready=1; rd_ready while empty SHALL be ignored.
REQ-020 FIFO SHALL be first-in first-out, circular read/write pointers wrapping at DEPTH.
REQ-021 Push while level=DEPTH with no pop in the same cycle SHALL drop the byte, leave FIFO contents and level unchanged, and set overflow; the assembly register still clears.
REQ-022 Simultaneous push and pop when level=DEPTH SHALL both succeed; level stays DEPTH, overflow unchanged.
REQ-023 Simultaneous push and pop at level=0 is impossible (rd_valid=0); push alone takes level to 1.
REQ-024 Simultaneous push and pop at 0<level<DEPTH SHALL leave level unchanged.
REQ-025 overflow SHALL remain set until reset; flush SHALL NOT clear it.
REQ-026 level SHALL equal pushes minus pops since reset at every edge, never exceeding DEPTH.

Reset
REQ-027 rst_n low SHALL immediately clear bit_count, level, read/write pointers, assembly register and overflow; rd_valid=0, rd_data=8'h00.
REQ-028 Reset asserted mid-byte or with a non-empty FIFO SHALL discard all held data; no partial byte is pushed.
REQ-029 After rst_n rises, the first edge with bit_valid=1 SHALL be accepted normally.

Verification
REQ-030 Reset, then bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> after 8th edge rd_valid=1, rd_data=8'h4D, level=1, bit_count=0.
REQ-031 Bits 1,1,1 then flush (bit_valid=0) -> rd_data=8'h07, bit_count=0; a second flush alone -> level unchanged.
REQ-032 Seven bits of 1 then bit 1 with flush in same cycle -> exactly one byte 8'hFF pushed, level increments by 1.
REQ-033 DEPTH=4, rd_ready=0, push 5 bytes 8'h01..8'h05 -> level=4, overflow=1, pops return 01,02,03,04 in order then rd_valid=0.
REQ-034 FIFO full, push and pop same cycle -> level stays 4, overflow stays 0, pop order preserved with new byte last.
REQ-035 Four bits accepted and 2 bytes queued, then rst_n pulsed low asynchronously between edges -> level=0, bit_count=0, rd_valid=0, overflow=0 immediately.
